// File: rtl/lcd_rgb_rx.sv
// RGB565 LCD stream receiver: pixel coordinates, frame-format measurement and lock.
// Optional blanking-data check (blank_err output) under LCD_RGB_RX_BLANK_CHECK_EN.
//   state  | meaning
//   SEARCH | waiting for the first VS edge, current frame discarded
//   TRACK  | measuring frames, counting consecutive identical formats
//   LOCKED | format stable, any violation drops back to TRACK
module lcd_rgb_rx #(
   parameter logic HS_POL      = 1'b1,
   parameter logic VS_POL      = 1'b1,
   parameter int   LOCK_FRAMES = 2
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        lcd_hs,
   input  logic        lcd_vs,
   input  logic        lcd_de,
   input  logic [15:0] lcd_rgb,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        line_start,
   output logic        frame_start,
   output logic [10:0] meas_hvalid,
   output logic [10:0] meas_htotal,
   output logic [10:0] meas_vvalid,
   output logic [10:0] meas_vtotal,
   output logic        locked,
   output logic        fmt_err
`ifdef LCD_RGB_RX_BLANK_CHECK_EN
  ,output logic        blank_err
`endif
);
   typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

   localparam logic [10:0] MAX      = 11'h7FF;
   localparam logic [3:0]  LOCK_TGT = 4'(LOCK_FRAMES - 1);

   logic        hs_q, hs_p_q, vs_q, vs_p_q, de_q, line_act_q, hval_set_q;
   logic [15:0] rgb_q;
   logic [10:0] x_cnt_q, y_q, h_cnt_q, v_cnt_q, htot_last_q, hval_frm_q;
   logic [21:0] wd_q;
   state_t      state_q;
   logic [3:0]  match_q;
   logic        pix_valid_q, line_start_q, frame_start_q, locked_q, fmt_err_q, blank_err_q;
   logic [15:0] pix_data_q;
   logic [10:0] pix_x_q, pix_y_q, meas_hval_q, meas_htot_q, meas_vval_q, meas_vtot_q;

   logic        hs_edge, vs_edge, de_rise, line_end, x_sat_err, hval_err, vs_de_err;
   logic        blank_hit, mid_err, fmt_match, wd_hit;
   logic [10:0] line_len, x_d, y_inc, y_d, hval_fin, vval_fin, htot_fin;
   logic [3:0]  match_d;

   always_comb begin
      hs_edge   = (hs_q == HS_POL) && (hs_p_q != HS_POL);
      vs_edge   = (vs_q == VS_POL) && (vs_p_q != VS_POL);
      // A VS edge during DE closes the running line; the pixel on that edge opens a new one.
      de_rise   = de_q && (!line_act_q || vs_edge);
      line_end  = line_act_q && (!de_q || vs_edge);
      line_len  = (x_cnt_q == MAX) ? MAX : x_cnt_q + 11'd1;
      x_d       = x_cnt_q;
      if (de_rise)
         x_d = 11'd0;
      else if (de_q && (x_cnt_q != MAX))
         x_d = x_cnt_q + 11'd1;
      x_sat_err = de_q && !de_rise && (x_cnt_q == MAX - 11'd1);
      y_inc     = (y_q == MAX) ? MAX : y_q + 11'd1;
      y_d       = vs_edge ? 11'd0 : (line_end ? y_inc : y_q);
      hval_err  = line_end && hval_set_q && (line_len != hval_frm_q);
      vs_de_err = vs_edge && de_q;
      hval_fin  = (line_end && !hval_set_q) ? line_len : hval_frm_q;
      vval_fin  = line_end ? y_inc : y_q;
      htot_fin  = hs_edge ? h_cnt_q : htot_last_q;
      fmt_match = (hval_fin == meas_hval_q) && (htot_fin == meas_htot_q) &&
                  (vval_fin == meas_vval_q) && (v_cnt_q == meas_vtot_q);
      match_d   = fmt_match ? ((match_q == 4'hF) ? 4'hF : match_q + 4'd1) : 4'd0;
`ifdef LCD_RGB_RX_BLANK_CHECK_EN
      blank_hit = !de_q && (rgb_q != 16'h0000);
`else
      blank_hit = 1'b0;
`endif
      mid_err   = x_sat_err || hval_err || vs_de_err || blank_hit;
      wd_hit    = &wd_q;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         {hs_q, hs_p_q, vs_q, vs_p_q, de_q, line_act_q, hval_set_q} <= '0;
         rgb_q       <= '0;
         x_cnt_q     <= '0;
         y_q         <= '0;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         htot_last_q <= '0;
         hval_frm_q  <= '0;
         wd_q        <= '0;
      end else begin
         hs_q        <= lcd_hs;
         hs_p_q      <= hs_q;
         vs_q        <= lcd_vs;
         vs_p_q      <= vs_q;
         de_q        <= lcd_de;
         rgb_q       <= lcd_rgb;
         line_act_q  <= de_q;
         x_cnt_q     <= x_d;
         y_q         <= y_d;
         h_cnt_q     <= hs_edge ? 11'd1 : ((h_cnt_q == MAX) ? MAX : h_cnt_q + 11'd1);
         if (hs_edge)
            htot_last_q <= h_cnt_q;
         if (vs_edge)
            v_cnt_q <= hs_edge ? 11'd1 : 11'd0;
         else if (hs_edge && (v_cnt_q != MAX))
            v_cnt_q <= v_cnt_q + 11'd1;
         if (vs_edge)
            hval_set_q <= 1'b0;
         else if (line_end && !hval_set_q) begin
            hval_frm_q <= line_len;
            hval_set_q <= 1'b1;
         end
         wd_q <= (vs_edge || wd_hit) ? 22'd0 : wd_q + 22'd1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= SEARCH;
         match_q       <= '0;
         {pix_valid_q, line_start_q, frame_start_q, locked_q, fmt_err_q, blank_err_q} <= '0;
         pix_data_q    <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         meas_hval_q   <= '0;
         meas_htot_q   <= '0;
         meas_vval_q   <= '0;
         meas_vtot_q   <= '0;
      end else begin
         pix_valid_q   <= de_q;
         pix_data_q    <= de_q ? rgb_q : 16'h0000;
         pix_x_q       <= de_q ? x_d : 11'd0;
         pix_y_q       <= de_q ? y_d : 11'd0;
         line_start_q  <= de_rise;
         frame_start_q <= vs_edge;
         blank_err_q   <= blank_hit;
         fmt_err_q     <= x_sat_err || hval_err || vs_de_err;
         if (vs_edge && (state_q != SEARCH)) begin
            meas_hval_q <= hval_fin;
            meas_htot_q <= htot_fin;
            meas_vval_q <= vval_fin;
            meas_vtot_q <= v_cnt_q;
         end
         case (state_q)
            SEARCH: if (vs_edge) begin
               state_q <= TRACK;
               match_q <= 4'd0;
            end
            TRACK: if (vs_edge) begin
               match_q <= match_d;
               if (match_d >= LOCK_TGT) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
               end
            end
            LOCKED: begin
               if (vs_edge && !fmt_match)
                  fmt_err_q <= 1'b1;
               if ((vs_edge && !fmt_match) || mid_err) begin
                  state_q  <= TRACK;
                  locked_q <= 1'b0;
                  match_q  <= 4'd0;
               end
            end
            default: state_q <= SEARCH;
         endcase
         if (wd_hit) begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
         end
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_data    = pix_data_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign meas_hvalid = meas_hval_q;
   assign meas_htotal = meas_htot_q;
   assign meas_vvalid = meas_vval_q;
   assign meas_vtotal = meas_vtot_q;
   assign locked      = locked_q;
   assign fmt_err     = fmt_err_q;
`ifdef LCD_RGB_RX_BLANK_CHECK_EN
   assign blank_err   = blank_err_q;
`endif
endmodule

// File: tb/tb_lcd_rgb_rx.sv
// Directed bench for lcd_rgb_rx on a scaled-down timing (H 2/3/16/4, V 1/2/6/2).
module tb_lcd_rgb_rx;
   localparam int HTOT = 25, HSYNC = 2, HBP = 3, HACT = 16;
   localparam int VTOT = 11, VSYNC = 1, VBP = 2, VACT = 6;

   logic        sys_clk = 1'b0, sys_rst_n = 1'b0;
   logic        lcd_hs = 1'b0, lcd_vs = 1'b0, lcd_de = 1'b0;
   logic [15:0] lcd_rgb = 16'h0;
   logic        pix_valid, line_start, frame_start, locked, fmt_err;
   logic [15:0] pix_data;
   logic [10:0] pix_x, pix_y, meas_hvalid, meas_htotal, meas_vvalid, meas_vtotal;
`ifdef LCD_RGB_RX_BLANK_CHECK_EN
   logic        blank_err;
`endif

   lcd_rgb_rx dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
      .line_start(line_start), .frame_start(frame_start),
      .meas_hvalid(meas_hvalid), .meas_htotal(meas_htotal),
      .meas_vvalid(meas_vvalid), .meas_vtotal(meas_vtotal),
      .locked(locked), .fmt_err(fmt_err)
`ifdef LCD_RGB_RX_BLANK_CHECK_EN
     ,.blank_err(blank_err)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {int x; int y; int d; int cyc;} pix_t;
   pix_t       sb[$];
   int         total = 0, bad = 0, cyc = 0, fmt_cnt = 0, f0 = 0;
   logic [3:0] vs_hist = '0, blk_hist = '0;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_flags"}, int'({pix_valid, line_start, frame_start, locked, fmt_err}), 0);
      chk({tag, "_data"}, int'(pix_data), 0);
      chk({tag, "_xy"}, int'({pix_x, pix_y}), 0);
      chk({tag, "_meas_h"}, int'({meas_hvalid, meas_htotal}), 0);
      chk({tag, "_meas_v"}, int'({meas_vvalid, meas_vtotal}), 0);
   endtask

   // Outputs seen at step n belong to inputs driven at step n-2.
   task automatic step(input logic hs, input logic vs, input logic de,
                       input logic [15:0] rgb, input int x, input int y);
      pix_t e;
      bit   exp_v;
      int   ls_exp;
      @(negedge sys_clk);
      cyc++;
      ls_exp = 0;
      while (sb.size() > 0 && sb[0].cyc + 2 < cyc) e = sb.pop_front();
      exp_v = (sb.size() > 0) && (sb[0].cyc + 2 == cyc);
      chk("pix_valid", int'(pix_valid), int'(exp_v));
      if (pix_valid && exp_v) begin
         e = sb.pop_front();
         chk("pix_x", int'(pix_x), e.x);
         chk("pix_y", int'(pix_y), e.y);
         chk("pix_data", int'(pix_data), e.d);
         ls_exp = int'(e.x == 0);
      end
      chk("line_start", int'(line_start), ls_exp);
      chk("frame_start", int'(frame_start), int'(vs_hist[1] & ~vs_hist[2]));
`ifdef LCD_RGB_RX_BLANK_CHECK_EN
      chk("blank_err", int'(blank_err), int'(blk_hist[1]));
`endif
      fmt_cnt += int'(fmt_err);
      vs_hist  = {vs_hist[2:0], vs};
      blk_hist = {blk_hist[2:0], (!de && rgb != 16'h0)};
      lcd_hs  = hs;
      lcd_vs  = vs;
      lcd_de  = de;
      lcd_rgb = rgb;
      if (de) sb.push_back('{x, y, int'(rgb), cyc});
   endtask

   task automatic run_line(input int ln, input int act, input bit glitch, input int lim);
      int tot, xi, n;
      logic de;
      logic [15:0] rgb;
      tot = (act <= HACT) ? HTOT : HSYNC + HBP + act + 4;
      n   = (lim < tot) ? lim : tot;
      for (int h = 0; h < n; h++) begin
         xi  = h - (HSYNC + HBP);
         de  = (ln >= VSYNC + VBP) && (ln < VSYNC + VBP + VACT) && (xi >= 0) && (xi < act);
         rgb = de ? 16'(xi) : ((glitch && h == HSYNC) ? 16'hF800 : 16'h0);
         step(h < HSYNC, ln < VSYNC, de, rgb, (xi > 2047) ? 2047 : xi, ln - (VSYNC + VBP));
      end
   endtask

   task automatic run_frame(input int act, input bit glitch);
      for (int ln = 0; ln < VTOT; ln++)
         run_line(ln, act, glitch && (ln == VSYNC + VBP + 1), 1 << 20);
   endtask

   initial begin
      repeat (3) @(negedge sys_clk);
      check_zero("reset");
      sys_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);

      // lock-in on nominal timing
      f0 = fmt_cnt;
      run_frame(HACT, 1'b0);
      run_frame(HACT, 1'b0);
      chk("locked_after_2vs", int'(locked), 0);
      run_frame(HACT, 1'b0);
      chk("locked_after_3vs", int'(locked), 1);
      chk("meas_hvalid", int'(meas_hvalid), HACT);
      chk("meas_htotal", int'(meas_htotal), HTOT);
      chk("meas_vvalid", int'(meas_vvalid), VACT);
      chk("meas_vtotal", int'(meas_vtotal), VTOT);
      chk("fmt_quiet_lockin", fmt_cnt - f0, 0);

      // one non-zero back-porch sample
      run_frame(HACT, 1'b1);
`ifdef LCD_RGB_RX_BLANK_CHECK_EN
      chk("locked_after_blank", int'(locked), 0);
`else
      chk("locked_after_blank", int'(locked), 1);
`endif
      run_frame(HACT, 1'b0);
      chk("locked_post_blank", int'(locked), 1);

      // width change 16 -> 15
      f0 = fmt_cnt;
      run_frame(HACT - 1, 1'b0);
      chk("locked_first_short", int'(locked), 1);
      run_frame(HACT - 1, 1'b0);
      chk("fmt_pulses_short", fmt_cnt - f0, 1);
      chk("locked_second_short", int'(locked), 0);
      run_frame(HACT - 1, 1'b0);
      chk("relocked_short", int'(locked), 1);
      chk("meas_hvalid_short", int'(meas_hvalid), HACT - 1);
      chk("meas_htotal_short", int'(meas_htotal), HTOT);
      for (int i = 0; i < 3; i++) run_frame(HACT, 1'b0);
      chk("relocked_nominal", int'(locked), 1);
      chk("meas_hvalid_nominal", int'(meas_hvalid), HACT);

      // DE held high for 2100 cycles on the first active line
      for (int ln = 0; ln < VSYNC + VBP; ln++) run_line(ln, HACT, 1'b0, 1 << 20);
      f0 = fmt_cnt;
      run_line(VSYNC + VBP, 2100, 1'b0, 1 << 20);
      chk("fmt_pulses_sat", fmt_cnt - f0, 1);
      chk("locked_after_sat", int'(locked), 0);
      for (int ln = VSYNC + VBP + 1; ln < VTOT; ln++) run_line(ln, HACT, 1'b0, 1 << 20);

      // asynchronous reset in the middle of an active line
      for (int ln = 0; ln < 5; ln++) run_line(ln, HACT, 1'b0, 1 << 20);
      run_line(5, HACT, 1'b0, 10);
      #2 sys_rst_n = 1'b0;
      #1 check_zero("arst");
      lcd_hs = 1'b0; lcd_vs = 1'b0; lcd_de = 1'b0; lcd_rgb = 16'h0;
      sb.delete();
      vs_hist  = '0;
      blk_hist = '0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int i = 0; i < 250; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 0, 0);
      run_frame(HACT, 1'b0);
      chk("post_rst_meas_h", int'({meas_hvalid, meas_htotal}), 0);
      chk("post_rst_meas_v", int'({meas_vvalid, meas_vtotal}), 0);
      chk("post_rst_locked_1vs", int'(locked), 0);
      run_frame(HACT, 1'b0);
      run_frame(HACT, 1'b0);
      chk("post_rst_locked_3vs", int'(locked), 1);
      chk("post_rst_meas_hvalid", int'(meas_hvalid), HACT);
      chk("post_rst_meas_vtotal", int'(meas_vtotal), VTOT);

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
